vga_console_tty_ctrl: RTL
=========================

Name: vga_console_tty_ctrl

Overview:
- Terminal-style front end for the VGA console text buffer.
- Accepts a byte stream of 7-bit characters on a valid/ready handshake and maintains a cursor.
- Writes printable glyphs into the NUM_ROWS x NUM_COLS buffer and sequences multi-cycle scroll and clear operations through the buffer's read and write ports.
- Sits between the host register interface and the text buffer RAM, so software no longer computes addresses or moves rows itself.

Parameters:
NUM_ROWS, 3, text rows in buffer
NUM_COLS, 10, text columns per row
ADDR_W, 5, buffer address width; must satisfy 2^ADDR_W >= NUM_ROWS*NUM_COLS

Ports:
clk  in  1  project clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  host presents in_char
in_char  in  7  character code
in_ready  out  1  controller accepts in_char this cycle
clear_req  in  1  single-cycle pulse: clear screen and home cursor
buf_raddr  out  ADDR_W  buffer read address (combinational from state)
buf_rdata  in  7  buffer read data, same-cycle combinational
buf_we  out  1  buffer write strobe (registered)
buf_waddr  out  ADDR_W  buffer write address (registered)
buf_wdata  out  7  buffer write data (registered)
cursor_row  out  $clog2(NUM_ROWS)  current row
cursor_col  out  $clog2(NUM_COLS)  current column
busy  out  1  scroll or clear in progress

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE, cursor (0,0), buf_we 0, buf_waddr 0, buf_wdata 0, busy 0, pending-clear flag 0. Buffer contents are not reset.
- States: IDLE, SCROLL_COPY, SCROLL_FILL, CLEAR. busy = (state != IDLE).
- in_ready = (state==IDLE) & ~clear_req & ~pend_clr. A handshake is in_valid & in_ready.
- Accepted character handling. Writes appear on buf_* the cycle after acceptance (1-cycle latency).
  - 0x20..0x7E: write char at row*NUM_COLS+col, then col+1.
    - If col was NUM_COLS-1: col=0 and a newline follows.
  - 0x0A (LF): col=0, then newline.
  - 0x0D (CR): col=0.
  - 0x08 (BS): col-1 if col>0, else no effect. Nothing is erased.
  - 0x0C (FF): same as clear_req.
  - Any other code: accepted, ignored.
- Newline: if row<NUM_ROWS-1 then row+1; otherwise row stays at NUM_ROWS-1 and the controller enters SCROLL_COPY.
- SCROLL_COPY:
  - Counter i runs 0..(NUM_ROWS-1)*NUM_COLS-1 with buf_raddr=i+NUM_COLS.
  - The next cycle writes buf_waddr=i, buf_wdata=buf_rdata.
  - Then SCROLL_FILL.
- SCROLL_FILL: writes 0x20 to the last row, addresses (NUM_ROWS-1)*NUM_COLS .. NUM_ROWS*NUM_COLS-1, one per cycle, then IDLE.
- CLEAR:
  - Writes 0x20 to addresses 0..NUM_ROWS*NUM_COLS-1, one per cycle, cursor set (0,0), then IDLE.
  - Entered on clear_req in IDLE (clear_req has priority over a same-cycle in_valid, which is not accepted).
- Busy timing with defaults: scroll holds busy for 30 cycles (20 copy + 10 fill); clear holds busy for 30 cycles.
- buf_we pulses exactly once per written cell. No write to an address >= NUM_ROWS*NUM_COLS ever occurs.
- clear_req while busy: sets pend_clr. CLEAR starts the cycle the current operation returns to IDLE, and pend_clr is then cleared. Multiple pulses collapse to one.
- Printable char at the last cell (row NUM_ROWS-1, col NUM_COLS-1): write, then scroll. The cursor ends at (NUM_ROWS-1, 0).
- Reset asserted mid-scroll or mid-clear: immediate IDLE with buf_we 0. The buffer is left partially updated; this is legal.
- Cursor outputs are stable during busy. They update in the acceptance cycle+1.

Decomposition:
- Shared package vga_console_pkg holds:
  - constants NUM_ROWS, NUM_COLS, NUM_CHARS;
  - character codes CH_LF, CH_CR, CH_BS, CH_FF, CH_SPACE;
  - the state enum.
- Natural sub-module: vga_console_fill_seq, a counter/address generator with start, base, length, copy_offset and mode (copy or fill) inputs and done output. Shared by SCROLL_COPY, SCROLL_FILL and CLEAR; the top holds the cursor and the FSM.

Test Plan:
- After reset, push 'A'(0x41), 'B' -> writes addr0=0x41, addr1=0x42 on consecutive post-accept cycles; cursor (0,2); busy 0.
- Push 10 printable chars from (0,0) -> tenth written at addr9; cursor (1,0); no scroll.
- Preload rows with 0x30/0x31/0x32, cursor (2,5), push LF -> busy 30 cycles; addr0..9=0x31, 10..19=0x32, 20..29=0x20; cursor (2,0); in_ready low throughout.
- Pulse clear_req during a scroll -> scroll completes, CLEAR follows immediately; all 30 cells =0x20; cursor (0,0); exactly 60 buf_we pulses in total.
- Cursor (1,0), push BS then CR then 0x07 -> cursor stays (1,0); no buf_we; each byte accepted in 1 cycle.
- Deassert rst_n at cycle 5 of CLEAR -> buf_we 0, busy 0, cursor (0,0), in_ready 1 on the first cycle after release.

Source files
------------

// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA console TTY front end: geometry, control
// character codes and the controller state encoding.
package vga_console_pkg;

    localparam int NUM_ROWS  = 3;
    localparam int NUM_COLS  = 10;
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;

    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SCROLL_COPY = 2'd1,
        SCROLL_FILL = 2'd2,
        CLEAR       = 2'd3
    } state_e;

    // Glyphs that land in the buffer: space through tilde inclusive.
    function automatic logic is_printable(input logic [6:0] c);
        return (c >= CH_SPACE) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/vga_console_fill_seq.sv
// Address sequencer for bulk buffer operations. Once started it walks
// 'length' consecutive cells from 'base', one per cycle. In copy mode each
// cell takes the data read from (cell + copy_offset); in fill mode it takes a
// space. 'done' is high during the final step.
module vga_console_fill_seq
    import vga_console_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] copy_offset,
    input  logic              mode,
    input  logic [6:0]        rdata,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [6:0]        wdata,
    output logic              active,
    output logic              done
);

    logic              active_r;
    logic              mode_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W-1:0] off_r;

    // Current step addresses and data, and detection of the final step.
    always_comb begin
        waddr  = base_r + cnt_r;
        active = active_r;
        if (active_r) begin
            raddr = base_r + cnt_r + off_r;
        end else begin
            raddr = '0;
        end
        if (mode_r) begin
            wdata = rdata;
        end else begin
            wdata = CH_SPACE;
        end
        done = active_r && ({1'b0, cnt_r} == (len_r - {{ADDR_W{1'b0}}, 1'b1}));
    end

    // Step counter; a new start reloads the operation even on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            mode_r   <= 1'b0;
            cnt_r    <= '0;
            base_r   <= '0;
            len_r    <= '0;
            off_r    <= '0;
        end else if (start) begin
            active_r <= 1'b1;
            mode_r   <= mode;
            cnt_r    <= '0;
            base_r   <= base;
            len_r    <= length;
            off_r    <= copy_offset;
        end else if (done) begin
            active_r <= 1'b0;
            cnt_r    <= '0;
        end else if (active_r) begin
            cnt_r    <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/vga_console_tty_ctrl.sv
// Terminal-style front end for the VGA console text buffer: consumes a
// character stream, tracks the cursor, writes glyphs and sequences scroll and
// clear through the buffer ports.
module vga_console_tty_ctrl #(
    parameter int NUM_ROWS = vga_console_pkg::NUM_ROWS,
    parameter int NUM_COLS = vga_console_pkg::NUM_COLS,
    parameter int ADDR_W   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [6:0]                  in_char,
    output logic                        in_ready,
    input  logic                        clear_req,
    output logic [ADDR_W-1:0]           buf_raddr,
    input  logic [6:0]                  buf_rdata,
    output logic                        buf_we,
    output logic [ADDR_W-1:0]           buf_waddr,
    output logic [6:0]                  buf_wdata,
    output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
    output logic [$clog2(NUM_COLS)-1:0] cursor_col,
    output logic                        busy
);
    import vga_console_pkg::*;

    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
    localparam int LAST_BASE = (NUM_ROWS - 1) * NUM_COLS;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    state_e            state_r;
    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic              pend_clr_r;
    logic              buf_we_r;
    logic [ADDR_W-1:0] buf_waddr_r;
    logic [6:0]        buf_wdata_r;

    logic [ROW_W-1:0]  row_n_s;
    logic [COL_W-1:0]  col_n_s;
    logic              accept_s;
    logic              wr_char_s;
    logic              newline_s;
    logic              go_clr_s;
    logic              go_scroll_s;
    logic              go_fill_s;
    logic [ADDR_W-1:0] cur_addr_s;

    logic              seq_start_s;
    logic [ADDR_W-1:0] seq_base_s;
    logic [ADDR_W:0]   seq_len_s;
    logic [ADDR_W-1:0] seq_off_s;
    logic              seq_mode_s;
    logic [ADDR_W-1:0] seq_waddr_s;
    logic [6:0]        seq_wdata_s;
    logic              seq_active_s;
    logic              seq_done_s;

    assign in_ready   = (state_r == IDLE) & ~clear_req & ~pend_clr_r;
    assign accept_s   = in_valid & in_ready;
    assign busy       = (state_r != IDLE);
    assign buf_we     = buf_we_r;
    assign buf_waddr  = buf_waddr_r;
    assign buf_wdata  = buf_wdata_r;
    assign cursor_row = row_r;
    assign cursor_col = col_r;
    assign cur_addr_s = ADDR_W'(row_r) * ADDR_W'(NUM_COLS) + ADDR_W'(col_r);

    // Decode the accepted character and operation completions into cursor
    // updates and operation launches.
    always_comb begin
        row_n_s     = row_r;
        col_n_s     = col_r;
        wr_char_s   = 1'b0;
        newline_s   = 1'b0;
        go_clr_s    = 1'b0;
        go_scroll_s = 1'b0;
        go_fill_s   = 1'b0;
        if (state_r == IDLE) begin
            if (clear_req | pend_clr_r) begin
                go_clr_s = 1'b1;
            end else if (accept_s) begin
                if (is_printable(in_char)) begin
                    wr_char_s = 1'b1;
                    if (col_r == COL_LAST) begin
                        col_n_s   = '0;
                        newline_s = 1'b1;
                    end else begin
                        col_n_s = col_r + COL_W'(1);
                    end
                end else begin
                    case (in_char)
                        CH_LF: begin
                            col_n_s   = '0;
                            newline_s = 1'b1;
                        end
                        CH_CR: col_n_s = '0;
                        CH_BS: begin
                            if (col_r != '0) begin
                                col_n_s = col_r - COL_W'(1);
                            end else begin
                                col_n_s = col_r;
                            end
                        end
                        CH_FF:   go_clr_s = 1'b1;
                        default: col_n_s = col_r;
                    endcase
                end
                if (newline_s) begin
                    if (row_r != ROW_LAST) begin
                        row_n_s = row_r + ROW_W'(1);
                    end else begin
                        go_scroll_s = 1'b1;
                    end
                end else begin
                    row_n_s = row_r;
                end
            end else begin
                go_clr_s = 1'b0;
            end
        end else if (seq_done_s) begin
            if (state_r == SCROLL_COPY) begin
                go_fill_s = 1'b1;
            end else if (clear_req | pend_clr_r) begin
                go_clr_s = 1'b1;
            end else begin
                go_fill_s = 1'b0;
            end
        end else begin
            go_fill_s = 1'b0;
        end
        if (go_clr_s) begin
            row_n_s = '0;
            col_n_s = '0;
        end else begin
            row_n_s = row_n_s;
        end
    end

    // Sequencer setup for whichever bulk operation is being launched.
    always_comb begin
        seq_start_s = go_clr_s | go_scroll_s | go_fill_s;
        if (go_clr_s) begin
            seq_base_s = '0;
            seq_len_s  = (ADDR_W+1)'(NUM_CELLS);
            seq_off_s  = '0;
            seq_mode_s = 1'b0;
        end else if (go_scroll_s) begin
            seq_base_s = '0;
            seq_len_s  = (ADDR_W+1)'(LAST_BASE);
            seq_off_s  = ADDR_W'(NUM_COLS);
            seq_mode_s = 1'b1;
        end else begin
            seq_base_s = ADDR_W'(LAST_BASE);
            seq_len_s  = (ADDR_W+1)'(NUM_COLS);
            seq_off_s  = '0;
            seq_mode_s = 1'b0;
        end
    end

    vga_console_fill_seq #(
        .ADDR_W (ADDR_W)
    ) u_fill_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (seq_start_s),
        .base        (seq_base_s),
        .length      (seq_len_s),
        .copy_offset (seq_off_s),
        .mode        (seq_mode_s),
        .rdata       (buf_rdata),
        .raddr       (buf_raddr),
        .waddr       (seq_waddr_s),
        .wdata       (seq_wdata_s),
        .active      (seq_active_s),
        .done        (seq_done_s)
    );

    // Controller state, cursor, pending clear and registered buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            row_r       <= '0;
            col_r       <= '0;
            pend_clr_r  <= 1'b0;
            buf_we_r    <= 1'b0;
            buf_waddr_r <= '0;
            buf_wdata_r <= '0;
        end else begin
            row_r <= row_n_s;
            col_r <= col_n_s;
            if (wr_char_s) begin
                buf_we_r    <= 1'b1;
                buf_waddr_r <= cur_addr_s;
                buf_wdata_r <= in_char;
            end else if (seq_active_s) begin
                buf_we_r    <= 1'b1;
                buf_waddr_r <= seq_waddr_s;
                buf_wdata_r <= seq_wdata_s;
            end else begin
                buf_we_r    <= 1'b0;
            end
            if (go_clr_s) begin
                pend_clr_r <= 1'b0;
            end else if (clear_req && (state_r != IDLE)) begin
                pend_clr_r <= 1'b1;
            end else begin
                pend_clr_r <= pend_clr_r;
            end
            case (state_r)
                IDLE: begin
                    if (go_clr_s) begin
                        state_r <= CLEAR;
                    end else if (go_scroll_s) begin
                        state_r <= SCROLL_COPY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCROLL_COPY: begin
                    if (go_fill_s) begin
                        state_r <= SCROLL_FILL;
                    end else begin
                        state_r <= SCROLL_COPY;
                    end
                end
                SCROLL_FILL, CLEAR: begin
                    if (go_clr_s) begin
                        state_r <= CLEAR;
                    end else if (seq_done_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
